// File: rtl/ps2_kbd_if.sv
// Bundle between the PS/2 receiver FIFO, the keyboard controller and its consumers.
// master: FIFO/environment side; slave: the controller.
interface ps2_kbd_if;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_repeat;
    logic [7:0] key_count;
    logic       shift;
    logic       ctrl;
    logic       caps;
    logic       ovf_seen;

    modport master (
        output ready, data, overflow,
        input  nextdata_n, key_valid, key_code, key_ext, key_break, key_repeat,
               key_count, shift, ctrl, caps, ovf_seen
    );

    modport slave (
        input  ready, data, overflow,
        output nextdata_n, key_valid, key_code, key_ext, key_break, key_repeat,
               key_count, shift, ctrl, caps, ovf_seen
    );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// Drains PS/2 scan-code bytes from the receiver FIFO, assembles Set-2 prefix
// sequences into key events and tracks modifier / Caps Lock / press-count state.
module ps2_kbd_ctrl #(
    parameter int              TO_W      = 24,
    parameter logic [TO_W-1:0] TIMEOUT   = TO_W'(1000000),
    parameter logic [2:0]      PAUSE_LEN = 3'd7
) (
    input  logic     clk,
    input  logic     clrn,
    ps2_kbd_if.slave bus
);
    localparam logic [7:0] C_E0    = 8'hE0;
    localparam logic [7:0] C_F0    = 8'hF0;
    localparam logic [7:0] C_E1    = 8'hE1;
    localparam logic [7:0] C_PAUSE = 8'h77;
    localparam logic [7:0] C_LSHFT = 8'h12;
    localparam logic [7:0] C_RSHFT = 8'h59;
    localparam logic [7:0] C_CTRL  = 8'h14;
    localparam logic [7:0] C_CAPS  = 8'h58;

    typedef enum logic [2:0] {S_IDLE, S_POP, S_SETTLE, S_DECODE, S_SKIP} state_t;

    state_t          state_reg, state_next;
    logic [7:0]      byte_reg, byte_next;
    logic            ext_p_reg, ext_p_next;
    logic            brk_p_reg, brk_p_next;
    logic            skip_act_reg, skip_act_next;
    logic [2:0]      skip_cnt_reg, skip_cnt_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            nextdata_n_reg, nextdata_n_next;
    logic            key_valid_reg, key_valid_next;
    logic [7:0]      key_code_reg, key_code_next;
    logic            key_ext_reg, key_ext_next;
    logic            key_break_reg, key_break_next;
    logic            key_repeat_reg, key_repeat_next;
    logic [7:0]      key_count_reg, key_count_next;
    logic            shift_reg, shift_next;
    logic            ctrl_reg, ctrl_next;
    logic            caps_reg, caps_next;
    logic            ovf_reg, ovf_next;
    logic            last_ext_reg, last_ext_next;
    logic [7:0]      last_code_reg, last_code_next;

    logic            ev_fire;
    logic [7:0]      ev_code;
    logic            ev_ext;
    logic            ev_brk;
    logic            ev_match;
    logic            ev_shift_key;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg      <= S_IDLE;
            byte_reg       <= '0;
            ext_p_reg      <= 1'b0;
            brk_p_reg      <= 1'b0;
            skip_act_reg   <= 1'b0;
            skip_cnt_reg   <= '0;
            to_cnt_reg     <= '0;
            nextdata_n_reg <= 1'b1;
            key_valid_reg  <= 1'b0;
            key_code_reg   <= '0;
            key_ext_reg    <= 1'b0;
            key_break_reg  <= 1'b0;
            key_repeat_reg <= 1'b0;
            key_count_reg  <= '0;
            shift_reg      <= 1'b0;
            ctrl_reg       <= 1'b0;
            caps_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
            last_ext_reg   <= 1'b0;
            last_code_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            byte_reg       <= byte_next;
            ext_p_reg      <= ext_p_next;
            brk_p_reg      <= brk_p_next;
            skip_act_reg   <= skip_act_next;
            skip_cnt_reg   <= skip_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            nextdata_n_reg <= nextdata_n_next;
            key_valid_reg  <= key_valid_next;
            key_code_reg   <= key_code_next;
            key_ext_reg    <= key_ext_next;
            key_break_reg  <= key_break_next;
            key_repeat_reg <= key_repeat_next;
            key_count_reg  <= key_count_next;
            shift_reg      <= shift_next;
            ctrl_reg       <= ctrl_next;
            caps_reg       <= caps_next;
            ovf_reg        <= ovf_next;
            last_ext_reg   <= last_ext_next;
            last_code_reg  <= last_code_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        byte_next       = byte_reg;
        ext_p_next      = ext_p_reg;
        brk_p_next      = brk_p_reg;
        skip_act_next   = skip_act_reg;
        skip_cnt_next   = skip_cnt_reg;
        to_cnt_next     = to_cnt_reg;
        nextdata_n_next = 1'b1;
        key_valid_next  = 1'b0;
        key_code_next   = key_code_reg;
        key_ext_next    = key_ext_reg;
        key_break_next  = key_break_reg;
        key_repeat_next = key_repeat_reg;
        key_count_next  = key_count_reg;
        shift_next      = shift_reg;
        ctrl_next       = ctrl_reg;
        caps_next       = caps_reg;
        ovf_next        = ovf_reg | bus.overflow;
        last_ext_next   = last_ext_reg;
        last_code_next  = last_code_reg;
        ev_fire         = 1'b0;
        ev_code         = byte_reg;
        ev_ext          = ext_p_reg;
        ev_brk          = brk_p_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.ready) begin
                    byte_next       = bus.data;
                    nextdata_n_next = 1'b0;
                    to_cnt_next     = '0;
                    state_next      = S_POP;
                end else if (ext_p_reg || brk_p_reg) begin
                    if (to_cnt_reg == TIMEOUT) begin
                        ext_p_next  = 1'b0;
                        brk_p_next  = 1'b0;
                        to_cnt_next = '0;
                    end else begin
                        to_cnt_next = to_cnt_reg + TO_W'(1);
                    end
                end else begin
                    to_cnt_next = '0;
                end
            end
            S_POP:    state_next = S_SETTLE;
            // Gives the receiver one cycle to update ready/data after the pop.
            S_SETTLE: state_next = skip_act_reg ? S_SKIP : S_DECODE;
            S_DECODE: begin
                state_next = S_IDLE;
                case (byte_reg)
                    C_E0: ext_p_next = 1'b1;
                    C_F0: brk_p_next = 1'b1;
                    C_E1: begin
                        ext_p_next    = 1'b0;
                        brk_p_next    = 1'b0;
                        skip_act_next = 1'b1;
                        skip_cnt_next = PAUSE_LEN;
                        to_cnt_next   = '0;
                        state_next    = S_SKIP;
                    end
                    8'h00, 8'hFF: begin
                        ext_p_next = 1'b0;
                        brk_p_next = 1'b0;
                    end
                    default: begin
                        ev_fire    = 1'b1;
                        ext_p_next = 1'b0;
                        brk_p_next = 1'b0;
                    end
                endcase
            end
            S_SKIP: begin
                if (skip_cnt_reg == 3'd0) begin
                    ev_fire       = 1'b1;
                    ev_code       = C_PAUSE;
                    ev_ext        = 1'b1;
                    ev_brk        = 1'b0;
                    skip_act_next = 1'b0;
                    state_next    = S_IDLE;
                end else if (bus.ready) begin
                    nextdata_n_next = 1'b0;
                    skip_cnt_next   = skip_cnt_reg - 3'd1;
                    to_cnt_next     = '0;
                    state_next      = S_POP;
                end else if (to_cnt_reg == TIMEOUT) begin
                    skip_act_next = 1'b0;
                    skip_cnt_next = '0;
                    to_cnt_next   = '0;
                    state_next    = S_IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase

        ev_match     = ({ev_ext, ev_code} == {last_ext_reg, last_code_reg});
        // Shift is tracked for the plain (non-E0) codes only; E0 12 is a fake shift.
        ev_shift_key = !ev_ext && (ev_code == C_LSHFT || ev_code == C_RSHFT);

        if (ev_fire) begin
            key_valid_next = 1'b1;
            key_code_next  = ev_code;
            key_ext_next   = ev_ext;
            key_break_next = ev_brk;
            if (!ev_brk) begin
                key_repeat_next = ev_match;
                if (!ev_match) begin
                    key_count_next = key_count_reg + 8'd1;
                    last_ext_next  = ev_ext;
                    last_code_next = ev_code;
                    if (!ev_ext && ev_code == C_CAPS)
                        caps_next = ~caps_reg;
                end
                if (ev_shift_key)
                    shift_next = 1'b1;
                if (ev_code == C_CTRL)
                    ctrl_next = 1'b1;
            end else begin
                key_repeat_next = 1'b0;
                if (ev_match) begin
                    last_ext_next  = 1'b0;
                    last_code_next = '0;
                end
                if (ev_shift_key)
                    shift_next = 1'b0;
                if (ev_code == C_CTRL)
                    ctrl_next = 1'b0;
            end
        end
    end

    assign bus.nextdata_n = nextdata_n_reg;
    assign bus.key_valid  = key_valid_reg;
    assign bus.key_code   = key_code_reg;
    assign bus.key_ext    = key_ext_reg;
    assign bus.key_break  = key_break_reg;
    assign bus.key_repeat = key_repeat_reg;
    assign bus.key_count  = key_count_reg;
    assign bus.shift      = shift_reg;
    assign bus.ctrl       = ctrl_reg;
    assign bus.caps       = caps_reg;
    assign bus.ovf_seen   = ovf_reg;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: directed scan-code tables, timeout/reset
// corner cases and a random byte stream checked against a per-byte reference model.
module tb_ps2_kbd_ctrl;
    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    ps2_kbd_if bus();

    ps2_kbd_ctrl #(.TO_W(24), .TIMEOUT(24'd100), .PAUSE_LEN(3'd7)) dut (
        .clk (clk),
        .clrn(clrn),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rep;
        logic [7:0] cnt;
        logic       shift;
        logic       ctrl;
        logic       caps;
    } ev_t;

    typedef struct {
        logic [7:0] b[8];
        int         n;
        int         nev;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rep;
        logic [7:0] cnt;
        logic       shift;
        logic       ctrl;
        logic       caps;
    } vec_t;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_pop_cyc = -10;
    int         pops = 0;
    logic [7:0] fifo_q[$];
    ev_t        act_q[$];
    ev_t        exp_q[$];
    vec_t       tbl[8];
    logic [7:0] pool[8] = '{8'h1C, 8'h12, 8'h59, 8'h14, 8'h58, 8'h75, 8'h77, 8'h5A};

    // reference model state
    logic       m_ext, m_brk, m_shift, m_ctrl, m_caps;
    int         m_pause, m_cnt;
    logic [8:0] m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [24:0] outs();
        return {bus.nextdata_n, bus.key_valid, bus.key_code, bus.key_ext, bus.key_break,
                bus.key_repeat, bus.key_count, bus.shift, bus.ctrl, bus.caps, bus.ovf_seen};
    endfunction

    // Receiver FIFO model plus pop-rule and event monitors.
    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (clrn && bus.nextdata_n === 1'b0) begin
            n_chk++;
            if (bus.ready !== 1'b1 || fifo_q.size() == 0 || cyc - last_pop_cyc < 3) begin
                n_fail++;
                $display("FAIL pop_rule: cycle %0d ready=%b gap=%0d (need ready=1, gap>=3)",
                         cyc, bus.ready, cyc - last_pop_cyc);
            end
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            last_pop_cyc = cyc;
            pops++;
        end
        if (clrn && bus.key_valid === 1'b1) begin
            e.code = bus.key_code; e.ext = bus.key_ext; e.brk = bus.key_break;
            e.rep = bus.key_repeat; e.cnt = bus.key_count; e.shift = bus.shift;
            e.ctrl = bus.ctrl; e.caps = bus.caps;
            act_q.push_back(e);
        end
        bus.ready = (fifo_q.size() != 0);
        bus.data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_shift = 0; m_ctrl = 0; m_caps = 0;
        m_pause = 0; m_cnt = 0; m_last = '0;
        exp_q.delete();
    endtask

    task automatic m_emit(input logic [7:0] c, input logic e, input logic k);
        ev_t        x;
        logic [8:0] key = {e, c};
        x.code = c; x.ext = e; x.brk = k; x.rep = 1'b0;
        if (!k) begin
            if (key == m_last) x.rep = 1'b1;
            else begin
                m_cnt  = (m_cnt + 1) % 256;
                m_last = key;
                if (key == 9'h058) m_caps = !m_caps;
            end
            if (key == 9'h012 || key == 9'h059) m_shift = 1'b1;
            if (c == 8'h14) m_ctrl = 1'b1;
        end else begin
            if (key == m_last) m_last = '0;
            if (key == 9'h012 || key == 9'h059) m_shift = 1'b0;
            if (c == 8'h14) m_ctrl = 1'b0;
        end
        x.cnt = 8'(m_cnt); x.shift = m_shift; x.ctrl = m_ctrl; x.caps = m_caps;
        exp_q.push_back(x);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) m_emit(8'h77, 1'b1, 1'b0);
        end else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE1) begin m_pause = 7; m_ext = 0; m_brk = 0; end
        else if (b == 8'h00 || b == 8'hFF) begin m_ext = 0; m_brk = 0; end
        else begin m_emit(b, m_ext, m_brk); m_ext = 0; m_brk = 0; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 clrn = 1'b0;
        fifo_q.delete();
        bus.ready = 1'b0;
        repeat (3) @(negedge clk);
        act_q.delete();
        pops = 0;
        #1 clrn = 1'b1;
    endtask

    task automatic push_bytes(input logic [7:0] b[8], input int n);
        @(posedge clk);
        #2;
        for (int i = 0; i < n; i++) fifo_q.push_back(b[i]);
    endtask

    task automatic push1(input logic [7:0] b);
        @(posedge clk);
        #2 fifo_q.push_back(b);
    endtask

    task automatic wait_drain();
        int quiet = 0;
        int t = 0;
        while (quiet < 10 && t < 20000) begin
            @(negedge clk);
            t++;
            if (fifo_q.size() == 0 && bus.nextdata_n === 1'b1) quiet++;
            else quiet = 0;
        end
        if (quiet < 10) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: fifo still holds %0d bytes, required 0", fifo_q.size());
        end
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_nevents"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_event%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        ev_t        last_ev;
        logic [7:0] b;
        int         t;

        clrn = 1'b0; bus.ready = 1'b0; bus.data = 8'h00; bus.overflow = 1'b0;
        tbl[0] = '{b:'{8'h1C,8'hF0,8'h1C,8'h00,8'h00,8'h00,8'h00,8'h00}, n:3, nev:2,
                   code:8'h1C, ext:0, brk:1, rep:0, cnt:8'd1, shift:0, ctrl:0, caps:0};
        tbl[1] = '{b:'{8'hE0,8'h75,8'hE0,8'hF0,8'h75,8'h00,8'h00,8'h00}, n:5, nev:2,
                   code:8'h75, ext:1, brk:1, rep:0, cnt:8'd1, shift:0, ctrl:0, caps:0};
        tbl[2] = '{b:'{8'h1C,8'h1C,8'h1C,8'hF0,8'h1C,8'h1C,8'h00,8'h00}, n:6, nev:5,
                   code:8'h1C, ext:0, brk:0, rep:0, cnt:8'd2, shift:0, ctrl:0, caps:0};
        tbl[3] = '{b:'{8'h12,8'h58,8'hF0,8'h58,8'h58,8'hF0,8'h12,8'h00}, n:7, nev:5,
                   code:8'h12, ext:0, brk:1, rep:0, cnt:8'd3, shift:0, ctrl:0, caps:0};
        tbl[4] = '{b:'{8'hE1,8'h14,8'h77,8'hE1,8'hF0,8'h14,8'hF0,8'h77}, n:8, nev:1,
                   code:8'h77, ext:1, brk:0, rep:0, cnt:8'd1, shift:0, ctrl:0, caps:0};
        tbl[5] = '{b:'{8'h14,8'hE0,8'h14,8'h00,8'h00,8'h00,8'h00,8'h00}, n:3, nev:2,
                   code:8'h14, ext:1, brk:0, rep:0, cnt:8'd2, shift:0, ctrl:1, caps:0};
        tbl[6] = '{b:'{8'hF0,8'h00,8'h1C,8'h00,8'h00,8'h00,8'h00,8'h00}, n:3, nev:1,
                   code:8'h1C, ext:0, brk:0, rep:0, cnt:8'd1, shift:0, ctrl:0, caps:0};
        tbl[7] = '{b:'{8'h59,8'hF0,8'hFF,8'h59,8'h00,8'h00,8'h00,8'h00}, n:4, nev:2,
                   code:8'h59, ext:0, brk:0, rep:1, cnt:8'd1, shift:1, ctrl:0, caps:0};

        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(outs()), {7'd0, 1'b1, 24'h0});
        clrn = 1'b1;

        // Directed table
        for (int k = 0; k < 8; k++) begin
            do_reset();
            model_reset();
            for (int i = 0; i < tbl[k].n; i++) model_byte(tbl[k].b[i]);
            push_bytes(tbl[k].b, tbl[k].n);
            wait_drain();
            check($sformatf("vec%0d_pops", k), pops, tbl[k].n);
            check($sformatf("vec%0d_nev", k), act_q.size(), tbl[k].nev);
            last_ev = (act_q.size() != 0) ? act_q[act_q.size()-1] : '0;
            check($sformatf("vec%0d_last_event", k),
                  {last_ev.code, last_ev.ext, last_ev.brk, last_ev.rep},
                  {tbl[k].code, tbl[k].ext, tbl[k].brk, tbl[k].rep});
            check($sformatf("vec%0d_state", k),
                  {bus.key_count, bus.shift, bus.ctrl, bus.caps},
                  {tbl[k].cnt, tbl[k].shift, tbl[k].ctrl, tbl[k].caps});
            compare_events($sformatf("vec%0d", k));
        end

        // Pending F0 survives a short gap
        do_reset();
        push1(8'hF0); wait_drain();
        repeat (40) @(negedge clk);
        push1(8'h1C); wait_drain();
        check("short_gap_break", {act_q.size() == 1, (act_q.size() != 0) ? act_q[0].brk : 1'b0}, 2'b11);

        // Pending F0 expires after the timeout
        do_reset();
        push1(8'hF0); wait_drain();
        repeat (150) @(negedge clk);
        push1(8'h1C); wait_drain();
        check("timeout_clears_break", {act_q.size() == 1, (act_q.size() != 0) ? act_q[0].brk : 1'b1}, 2'b10);

        // SKIP abandoned after the timeout
        do_reset();
        push1(8'hE1); push1(8'h14); wait_drain();
        repeat (150) @(negedge clk);
        push1(8'h1C); wait_drain();
        last_ev = (act_q.size() != 0) ? act_q[0] : '0;
        check("skip_timeout", {act_q.size() == 1, last_ev.code, last_ev.ext}, {1'b1, 8'h1C, 1'b0});

        // Asynchronous reset in the middle of SKIP
        do_reset();
        push1(8'h14); wait_drain();
        b = 8'hE1; push1(b); push1(8'h14); push1(8'h77);
        t = 0;
        while (pops < 3 && t < 200) begin @(negedge clk); t++; end
        check("mid_skip_reached", pops, 3);
        #2 clrn = 1'b0;
        #1 check("mid_skip_async_reset", 32'(outs()), {7'd0, 1'b1, 24'h0});
        fifo_q.delete(); bus.ready = 1'b0;
        repeat (2) @(negedge clk);
        act_q.delete();
        #1 clrn = 1'b1;
        push1(8'h1C); wait_drain();
        last_ev = (act_q.size() != 0) ? act_q[0] : '0;
        check("after_mid_skip_reset", {act_q.size() == 1, last_ev.code, last_ev.ext, last_ev.cnt},
              {1'b1, 8'h1C, 1'b0, 8'd1});

        // Reset while nextdata_n is low
        push1(8'h5A);
        t = 0;
        while (bus.nextdata_n !== 1'b0 && t < 50) begin @(posedge clk); #1; t++; end
        check("pop_low_seen", bus.nextdata_n, 1'b0);
        #1 clrn = 1'b0;
        #1 check("pop_low_async_reset", 32'(outs()), {7'd0, 1'b1, 24'h0});
        fifo_q.delete(); bus.ready = 1'b0;
        @(negedge clk);
        #1 clrn = 1'b1;

        // Sticky overflow
        do_reset();
        @(posedge clk); #2 bus.overflow = 1'b1;
        @(posedge clk); #2 bus.overflow = 1'b0;
        repeat (20) @(negedge clk);
        check("ovf_sticky", bus.ovf_seen, 1'b1);
        do_reset();
        #1 check("ovf_cleared_by_reset", bus.ovf_seen, 1'b0);

        // Random stream against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 12)      b = 8'hE0;
            else if (r < 24) b = 8'hF0;
            else if (r < 27) b = 8'hE1;
            else if (r < 30) b = (r == 28) ? 8'hFF : 8'h00;
            else if (r < 36) b = 8'($urandom_range(1, 254));
            else             b = pool[$urandom_range(0, 7)];
            model_byte(b);
            push1(b);
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        wait_drain();
        compare_events("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
